// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS-subset controller: FSM states, opcode/funct
// codes, ALU selectors, mux encodings and the decoded control-output bundle.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_MEM, BRANCH, JUMP, ILLEGAL, TRAP
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05,
    OP_XORI  = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_AND, ALU_NAND, ALU_NOR, ALU_OR
  } alu_t;

  typedef enum logic [1:0] {JMP_PC4, JMP_TGT, JMP_RS}     jump_t;
  typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31}         reg_dst_t;
  typedef enum logic [1:0] {M2R_ALU, M2R_MEM, M2R_PC4}    m2r_t;
  typedef enum logic [1:0] {TC_NONE, TC_ILLEGAL, TC_TIMEOUT} trap_cause_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       alu_src;
    logic       jal;
    logic [1:0] jump;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ctrl;
    logic       retired;
  } ctrl_out_t;

  function automatic state_t decode_op(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: s = EXEC_R;
          FN_JR:                  s = JUMP;
          default:                s = ILLEGAL;
        endcase
      end
      OP_LW, OP_SW:  s = MEM_ADDR;
      OP_XORI:       s = EXEC_I;
      OP_BNE:        s = BRANCH;
      OP_J, OP_JAL:  s = JUMP;
      default:       s = ILLEGAL;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      FN_SUB:  a = ALU_SUB;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = sequencer (drives selects/enables),
// slave = datapath (drives instruction fields, flags and memory handshake).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       branch;
  logic       alu_src;
  logic       jal;
  logic [1:0] jump;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic       retired;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, branch, alu_src,
           jal, jump, reg_dst, mem_to_reg, alu_ctrl, state, retired, trap, trap_cause
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, branch, alu_src,
           jal, jump, reg_dst, mem_to_reg, alu_ctrl, state, retired, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait-states; timeout fires combinationally on the
// LIMIT-th stalled cycle so the sequencer can suppress enables in that same cycle.
module mem_wait_timer #(
  parameter int WAIT_W = 4,
  parameter int LIMIT  = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  input  logic state_chg,
  output logic timeout
);
  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (!active || mem_ready || state_chg) cnt <= '0;
    else                                    cnt <= cnt + WAIT_W'(1);
  end

  assign timeout = active && !mem_ready && (cnt == WAIT_W'(LIMIT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Build option: ILLEGAL_TRAP_EN makes undecodable instructions trap instead of retiring as NOPs.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_W         = 4,
  parameter int MEM_WAIT_LIMIT = 15
) (
  input logic          clk,
  input logic          reset,
  multicycle_ctrl_if.master bus
);
  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic       trap_q;
  logic [1:0] cause_q;
  ctrl_out_t  o;
  logic       waiting, timeout;
  logic       unused_zero;

  // Branch resolution (branch & ~zero) lives in the PC unit.
  assign unused_zero = bus.zero;

  assign waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  mem_wait_timer #(.WAIT_W(WAIT_W), .LIMIT(MEM_WAIT_LIMIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (waiting),
    .mem_ready (bus.mem_ready),
    .state_chg (state_d != state_q),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      op_q    <= '0;
      fn_q    <= '0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      if (state_d == TRAP && state_q != TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= timeout ? TC_TIMEOUT : TC_ILLEGAL;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    o       = '0;
    case (state_q)
      S_RESET: state_d = FETCH;
      FETCH: begin
        o.mem_read = 1'b1;
        o.alu_ctrl = ALU_ADD;
        if (timeout) begin
          o       = '0;
          state_d = TRAP;
        end else if (bus.mem_ready) begin
          o.ir_write = 1'b1;
          o.pc_write = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: state_d = decode_op(bus.opcode, bus.funct);
      EXEC_R: begin
        o.alu_src  = 1'b0;
        o.alu_ctrl = funct_alu(fn_q);
        state_d    = WB_R;
      end
      EXEC_I: begin
        o.alu_src  = 1'b1;
        o.alu_ctrl = ALU_XOR;
        state_d    = WB_I;
      end
      MEM_ADDR: begin
        o.alu_src  = 1'b1;
        o.alu_ctrl = ALU_ADD;
        state_d    = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        o.mem_read = 1'b1;
        if (timeout) begin
          o       = '0;
          state_d = TRAP;
        end else if (bus.mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        o.mem_write = 1'b1;
        if (timeout) begin
          o       = '0;
          state_d = TRAP;
        end else if (bus.mem_ready) begin
          o.retired = 1'b1;
          state_d   = FETCH;
        end
      end
      WB_R: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = RD_RD;
        o.mem_to_reg = M2R_ALU;
        o.retired    = 1'b1;
        state_d      = FETCH;
      end
      WB_I: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = RD_RT;
        o.mem_to_reg = M2R_ALU;
        o.retired    = 1'b1;
        state_d      = FETCH;
      end
      WB_MEM: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = RD_RT;
        o.mem_to_reg = M2R_MEM;
        o.retired    = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        o.alu_ctrl = ALU_SUB;
        o.branch   = 1'b1;
        o.pc_write = 1'b1;
        o.retired  = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        o.pc_write = 1'b1;
        o.retired  = 1'b1;
        // Only R-type reaches JUMP besides J/JAL, and that is JR.
        o.jump     = (op_q == OP_J || op_q == OP_JAL) ? JMP_TGT : JMP_RS;
        if (op_q == OP_JAL) begin
          o.jal        = 1'b1;
          o.reg_dst    = RD_R31;
          o.mem_to_reg = M2R_PC4;
          o.reg_write  = 1'b1;
        end
        state_d = FETCH;
      end
      ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = TRAP;
`else
        o.retired = 1'b1;
        state_d   = FETCH;
`endif
      end
      TRAP:    state_d = TRAP;
      default: state_d = S_RESET;
    endcase
  end

  assign bus.pc_write   = o.pc_write;
  assign bus.ir_write   = o.ir_write;
  assign bus.mem_read   = o.mem_read;
  assign bus.mem_write  = o.mem_write;
  assign bus.reg_write  = o.reg_write;
  assign bus.branch     = o.branch;
  assign bus.alu_src    = o.alu_src;
  assign bus.jal        = o.jal;
  assign bus.jump       = o.jump;
  assign bus.reg_dst    = o.reg_dst;
  assign bus.mem_to_reg = o.mem_to_reg;
  assign bus.alu_ctrl   = o.alu_ctrl;
  assign bus.retired    = o.retired;
  assign bus.state      = state_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction table plus hand-written
// wait-state, timeout, illegal-opcode and mid-write reset sequences.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.WAIT_W(4), .MEM_WAIT_LIMIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [3:0]  st;
    bit          full;
    logic [20:0] outs;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          n;
    state_t      s3, s4, s5;
    logic [20:0] mid;
    logic [20:0] fin;
  } vec_t;
  vec_t tbl[10];

  // {pc,ir,mr,mw,rw,br,as,jal,jump[2],reg_dst[2],m2r[2],alu[3],ret,trap,cause[2]}
  function automatic logic [20:0] o(input bit pc, ir, mr, mw, rw, br, as, jl,
                                     input logic [1:0] jp, rd, m2r,
                                     input logic [2:0] alu,
                                     input bit ret, tr, input logic [1:0] tc);
    return {pc, ir, mr, mw, rw, br, as, jl, jp, rd, m2r, alu, ret, tr, tc};
  endfunction

  function automatic logic [20:0] act();
    return {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
            bus.branch, bus.alu_src, bus.jal, bus.jump, bus.reg_dst, bus.mem_to_reg,
            bus.alu_ctrl, bus.retired, bus.trap, bus.trap_cause};
  endfunction

  logic [20:0] Z, F_RDY, F_WAIT, MRD, MWR;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic push(input string nm, input state_t st, input bit full, input logic [20:0] ov);
    exp_t e;
    e.nm = nm; e.st = st; e.full = full; e.outs = ov;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, compare against the scoreboard mid-cycle, advance.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr);
    exp_t e;
    bus.opcode = op; bus.funct = fn; bus.mem_ready = mr;
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got empty queue want expected entry");
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_state"}, 32'(bus.state), 32'(e.st));
      if (e.full) chk({e.nm, "_outs"}, 32'(act()), 32'(e.outs));
    end
    @(posedge clk); #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous drop, release one edge later.
  task automatic reset_mid(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, "_rst_state"}, 32'(bus.state), 32'(S_RESET));
    chk({nm, "_rst_outs"},  32'(act()), 32'(Z));
    @(posedge clk); #1;
    reset = 1'b0;
    push({nm, "_sreset"}, S_RESET, 1, Z);
    cyc(6'h00, 6'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Z      = '0;
    F_RDY  = o(1,1,1,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,0,0,2'd0);
    F_WAIT = o(0,0,1,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,0,0,2'd0);
    MRD    = F_WAIT;
    MWR    = o(0,0,0,1,0,0,0,0,2'd0,2'd0,2'd0,3'd0,0,0,2'd0);

    tbl[0] = '{"ADD",  6'h00, 6'h20, 4, EXEC_R,   WB_R,   S_RESET, Z,
               o(0,0,0,0,1,0,0,0,2'd0,2'd1,2'd0,3'd0,1,0,2'd0)};
    tbl[1] = '{"SUB",  6'h00, 6'h22, 4, EXEC_R,   WB_R,   S_RESET,
               o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd1,0,0,2'd0),
               o(0,0,0,0,1,0,0,0,2'd0,2'd1,2'd0,3'd0,1,0,2'd0)};
    tbl[2] = '{"SLT",  6'h00, 6'h2A, 4, EXEC_R,   WB_R,   S_RESET,
               o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd3,0,0,2'd0),
               o(0,0,0,0,1,0,0,0,2'd0,2'd1,2'd0,3'd0,1,0,2'd0)};
    tbl[3] = '{"XORI", 6'h0E, 6'h15, 4, EXEC_I,   WB_I,   S_RESET,
               o(0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0,3'd2,0,0,2'd0),
               o(0,0,0,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,1,0,2'd0)};
    tbl[4] = '{"LW",   6'h23, 6'h00, 5, MEM_ADDR, MEM_RD, WB_MEM,
               o(0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0,3'd0,0,0,2'd0),
               o(0,0,0,0,1,0,0,0,2'd0,2'd0,2'd1,3'd0,1,0,2'd0)};
    tbl[5] = '{"SW",   6'h2B, 6'h00, 4, MEM_ADDR, MEM_WR, S_RESET,
               o(0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0,3'd0,0,0,2'd0),
               o(0,0,0,1,0,0,0,0,2'd0,2'd0,2'd0,3'd0,1,0,2'd0)};
    tbl[6] = '{"BNE",  6'h05, 6'h00, 3, BRANCH,   S_RESET, S_RESET,
               o(1,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,3'd1,1,0,2'd0), Z};
    tbl[7] = '{"J",    6'h02, 6'h00, 3, JUMP,     S_RESET, S_RESET,
               o(1,0,0,0,0,0,0,0,2'd1,2'd0,2'd0,3'd0,1,0,2'd0), Z};
    tbl[8] = '{"JAL",  6'h03, 6'h00, 3, JUMP,     S_RESET, S_RESET,
               o(1,0,0,0,1,0,0,1,2'd1,2'd2,2'd2,3'd0,1,0,2'd0), Z};
    tbl[9] = '{"JR",   6'h00, 6'h08, 3, JUMP,     S_RESET, S_RESET,
               o(1,0,0,0,0,0,0,0,2'd2,2'd0,2'd0,3'd0,1,0,2'd0), Z};

    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    // Reset state
    #2;
    chk("reset_state", 32'(bus.state), 32'(S_RESET));
    chk("reset_outs",  32'(act()), 32'(Z));
    @(posedge clk); #1;
    reset = 1'b0;
    push("sreset", S_RESET, 1, Z);
    cyc(6'h00, 6'h00, 1'b1);

    // Table: opcode changes to garbage after DECODE to prove it was latched
    for (int i = 0; i < 10; i++) begin
      push({tbl[i].nm, "_c1"}, FETCH,  1, F_RDY);
      push({tbl[i].nm, "_c2"}, DECODE, 1, Z);
      push({tbl[i].nm, "_c3"}, tbl[i].s3, 1, tbl[i].mid);
      if (tbl[i].n == 4) push({tbl[i].nm, "_c4"}, tbl[i].s4, 1, tbl[i].fin);
      if (tbl[i].n == 5) begin
        push({tbl[i].nm, "_c4"}, tbl[i].s4, 0, Z);
        push({tbl[i].nm, "_c5"}, tbl[i].s5, 1, tbl[i].fin);
      end
      for (int k = 1; k <= tbl[i].n; k++)
        if (k <= 2) cyc(tbl[i].op, tbl[i].fn, 1'b1);
        else        cyc(6'h3F, 6'h3F, 1'b1);
    end

    // LW with 3 wait-states in MEM_RD; mem_ready=0 in DECODE/MEM_ADDR is ignored
    push("lww_f", FETCH, 1, F_RDY);   cyc(6'h23, 6'h00, 1'b1);
    push("lww_d", DECODE, 1, Z);      cyc(6'h23, 6'h00, 1'b0);
    push("lww_a", MEM_ADDR, 1, tbl[4].mid); cyc(6'h00, 6'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push("lww_rdw", MEM_RD, 1, MRD); cyc(6'h00, 6'h00, 1'b0);
    end
    push("lww_rdr", MEM_RD, 1, MRD);  cyc(6'h00, 6'h00, 1'b1);
    push("lww_wb", WB_MEM, 1, tbl[4].fin); cyc(6'h00, 6'h00, 1'b0);

    // 14 FETCH waits (one short of the limit) must not trap
    for (int k = 0; k < 14; k++) begin
      push("addw_fw", FETCH, 1, F_WAIT); cyc(6'h00, 6'h20, 1'b0);
    end
    push("addw_f", FETCH, 1, F_RDY);  cyc(6'h00, 6'h20, 1'b1);
    push("addw_d", DECODE, 1, Z);     cyc(6'h00, 6'h20, 1'b1);
    push("addw_e", EXEC_R, 1, Z);     cyc(6'h00, 6'h20, 1'b1);
    push("addw_wb", WB_R, 1, tbl[0].fin); cyc(6'h00, 6'h20, 1'b1);

    // SW with 14 MEM_WR waits
    push("sww_f", FETCH, 1, F_RDY);   cyc(6'h2B, 6'h00, 1'b1);
    push("sww_d", DECODE, 1, Z);      cyc(6'h2B, 6'h00, 1'b1);
    push("sww_a", MEM_ADDR, 1, tbl[5].mid); cyc(6'h2B, 6'h00, 1'b1);
    for (int k = 0; k < 14; k++) begin
      push("sww_ww", MEM_WR, 1, MWR); cyc(6'h2B, 6'h00, 1'b0);
    end
    push("sww_wr", MEM_WR, 1, tbl[5].fin); cyc(6'h2B, 6'h00, 1'b1);

    // Illegal opcode 3F
    push("ill_f", FETCH, 1, F_RDY);   cyc(6'h3F, 6'h00, 1'b1);
    push("ill_d", DECODE, 1, Z);      cyc(6'h3F, 6'h00, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    push("ill_x", ILLEGAL, 1, Z);     cyc(6'h00, 6'h00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      push("ill_trap", TRAP, 1, o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,0,1,2'd1));
      cyc(6'h00, 6'h20, 1'b1);
    end
    reset_mid("ill");
`else
    push("ill_x", ILLEGAL, 1, o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,1,0,2'd0));
    cyc(6'h00, 6'h00, 1'b1);
    // R-type with an unsupported funct is illegal too
    push("illr_f", FETCH, 1, F_RDY);  cyc(6'h00, 6'h24, 1'b1);
    push("illr_d", DECODE, 1, Z);     cyc(6'h00, 6'h24, 1'b1);
    push("illr_x", ILLEGAL, 1, o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,1,0,2'd0));
    cyc(6'h00, 6'h24, 1'b1);
`endif

    // Timeout: 15th consecutive FETCH wait traps with no enables
    for (int k = 0; k < 14; k++) begin
      push("to_fw", FETCH, 1, F_WAIT); cyc(6'h00, 6'h20, 1'b0);
    end
    push("to_last", FETCH, 1, Z);     cyc(6'h00, 6'h20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push("to_trap", TRAP, 1, o(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,0,1,2'd2));
      cyc(6'h00, 6'h20, 1'b1);
    end
    reset_mid("to");

    // Reset while mem_write is asserted
    push("rw_f", FETCH, 1, F_RDY);    cyc(6'h2B, 6'h00, 1'b1);
    push("rw_d", DECODE, 1, Z);       cyc(6'h2B, 6'h00, 1'b1);
    push("rw_a", MEM_ADDR, 1, tbl[5].mid); cyc(6'h2B, 6'h00, 1'b1);
    push("rw_w", MEM_WR, 1, MWR);     cyc(6'h2B, 6'h00, 1'b0);
    chk("rw_mem_write_pre", 32'(bus.mem_write), 32'd1);
    reset_mid("rw");
    push("rw_fetch", FETCH, 1, F_RDY); cyc(6'h00, 6'h20, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
